// File: rtl/integrator_chain_pkg.sv
// Shared constants and parameter checks for the cascaded integrator chain.
package integrator_chain_pkg;

  localparam int INT_WRAP = 0;
  localparam int INT_SAT  = 1;

  // Legal geometry: accumulator at least as wide as the input, 1..8 stages.
  function automatic bit params_ok(int n, int m, int k);
    return (m >= n) && (k >= 1) && (k <= 8);
  endfunction

endpackage

// File: rtl/integrator_chain_if.sv
// Sample/result bundle between a producer and the integrator chain.
interface integrator_chain_if #(
  parameter int n = 16,
  parameter int m = 24
);
  logic                in_valid;
  logic signed [n-1:0] in;
  logic                dump;
  logic signed [m-1:0] out;
  logic                out_valid;
  logic                sat_flag;

  modport master (
    output in_valid, in, dump,
    input  out, out_valid, sat_flag
  );

  modport slave (
    input  in_valid, in, dump,
    output out, out_valid, sat_flag
  );
endinterface

// File: rtl/integrator_chain_stage.sv
// One integrator: m-bit accumulator, m+1-bit sum, wrap or clamp, sticky clamp flag.
module integrator_chain_stage
  import integrator_chain_pkg::*;
#(
  parameter int m     = 24,
  parameter int sat   = INT_WRAP,
  parameter bit first = 1'b0
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic                dump,
  input  logic signed [m-1:0] add_in,
  output logic signed [m-1:0] acc,
  output logic                clamp
);

  logic signed [m:0]   sum;
  logic signed [m-1:0] nxt;
  logic                hit;

  assign sum = {acc[m-1], acc} + {add_in[m-1], add_in};

  // Overflow shows as the two top bits of the wide sum disagreeing.
  always_comb begin
    nxt = sum[m-1:0];
    hit = 1'b0;
    if (sat == INT_SAT && (sum[m] ^ sum[m-1])) begin
      hit = 1'b1;
      nxt = sum[m] ? {1'b1, {(m-1){1'b0}}} : {1'b0, {(m-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc   <= '0;
      clamp <= 1'b0;
    end else if (dump) begin
      // Restart: only the head stage picks up the sample that arrives with dump.
      acc   <= (en && first) ? add_in : '0;
      clamp <= 1'b0;
    end else if (en) begin
      acc   <= nxt;
      clamp <= clamp | hit;
    end
  end

endmodule

// File: rtl/integrator_chain.sv
// k cascaded signed integrators with valid qualification, dump and wrap/saturate.
module integrator_chain
  import integrator_chain_pkg::*;
#(
  parameter int n   = 16,
  parameter int m   = 24,
  parameter int k   = 3,
  parameter int sat = INT_WRAP
) (
  input logic               clk,
  input logic               clr_n,
  integrator_chain_if.slave bus
);

  if (!params_ok(n, m, k)) begin : g_bad_params
    $error("integrator_chain: need m >= n and 1 <= k <= 8");
  end

  logic [k-1:0][m-1:0] acc;
  logic [k-1:0][m-1:0] stage_in;
  logic [k-1:0]        clamp;
  logic                vld;

  for (genvar j = 0; j < k; j++) begin : g_stage
    if (j == 0) begin : g_head
      assign stage_in[j] = m'(bus.in);
    end else begin : g_tail
      assign stage_in[j] = acc[j-1];
    end

    integrator_chain_stage #(
      .m     (m),
      .sat   (sat),
      .first (j == 0)
    ) u_stage (
      .clk    (clk),
      .clr_n  (clr_n),
      .en     (bus.in_valid),
      .dump   (bus.dump),
      .add_in (stage_in[j]),
      .acc    (acc[j]),
      .clamp  (clamp[j])
    );
  end

  // A dump with a sample still counts as an accepted sample.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) vld <= 1'b0;
    else        vld <= bus.in_valid;
  end

  assign bus.out       = acc[k-1];
  assign bus.out_valid = vld;
  assign bus.sat_flag  = (sat == INT_SAT) ? |clamp : 1'b0;

endmodule

// File: tb/tb_integrator_chain.sv
// Random and directed checks of four chain geometries against a per-sample model.
module tb_integrator_chain;
  import integrator_chain_pkg::*;

  localparam int ND = 4;
  localparam int MM [ND] = '{24, 16, 16, 18};
  localparam int KK [ND] = '{3, 1, 1, 3};
  localparam int SS [ND] = '{INT_WRAP, INT_WRAP, INT_SAT, INT_SAT};

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic               v = 1'b0;
  logic               d = 1'b0;
  logic signed [15:0] x = '0;

  integrator_chain_if #(.n(16), .m(24)) b0 ();
  integrator_chain_if #(.n(16), .m(16)) b1 ();
  integrator_chain_if #(.n(16), .m(16)) b2 ();
  integrator_chain_if #(.n(16), .m(18)) b3 ();

  assign b0.in_valid = v; assign b0.in = x; assign b0.dump = d;
  assign b1.in_valid = v; assign b1.in = x; assign b1.dump = d;
  assign b2.in_valid = v; assign b2.in = x; assign b2.dump = d;
  assign b3.in_valid = v; assign b3.in = x; assign b3.dump = d;

  integrator_chain #(.n(16), .m(24), .k(3), .sat(INT_WRAP)) u0 (.clk(clk), .clr_n(clr_n), .bus(b0.slave));
  integrator_chain #(.n(16), .m(16), .k(1), .sat(INT_WRAP)) u1 (.clk(clk), .clr_n(clr_n), .bus(b1.slave));
  integrator_chain #(.n(16), .m(16), .k(1), .sat(INT_SAT))  u2 (.clk(clk), .clr_n(clr_n), .bus(b2.slave));
  integrator_chain #(.n(16), .m(18), .k(3), .sat(INT_SAT))  u3 (.clk(clk), .clr_n(clr_n), .bus(b3.slave));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: ideal integrator values per stage, reduced to the m-bit range.
  longint acc [ND][8];
  bit     ev  [ND];
  bit     ef  [ND];

  function automatic longint fixv(longint val, int mw, int s, output bit c);
    longint hi = (longint'(1) <<< (mw - 1)) - 1;
    longint lo = -(longint'(1) <<< (mw - 1));
    longint span = longint'(1) <<< mw;
    longint r;
    c = 1'b0;
    if (s == INT_SAT) begin
      if (val > hi) begin r = hi; c = 1'b1; end
      else if (val < lo) begin r = lo; c = 1'b1; end
      else r = val;
    end else begin
      r = val % span;
      if (r > hi) r = r - span;
      if (r < lo) r = r + span;
    end
    return r;
  endfunction

  task automatic mdl_reset();
    for (int u = 0; u < ND; u++) begin
      for (int j = 0; j < 8; j++) acc[u][j] = 0;
      ev[u] = 1'b0;
      ef[u] = 1'b0;
    end
  endtask

  task automatic mdl_step(bit vv, longint xx, bit dd);
    for (int u = 0; u < ND; u++) begin
      longint old [8];
      bit c;
      for (int j = 0; j < 8; j++) old[j] = acc[u][j];
      if (dd) begin
        for (int j = 0; j < 8; j++) acc[u][j] = 0;
        if (vv) acc[u][0] = xx;
        ef[u] = 1'b0;
      end else if (vv) begin
        for (int j = 0; j < KK[u]; j++) begin
          acc[u][j] = fixv(old[j] + ((j == 0) ? xx : old[j-1]), MM[u], SS[u], c);
          if (c) ef[u] = 1'b1;
        end
      end
      ev[u] = vv;
    end
  endtask

  task automatic lit(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int u, longint o, bit vo, bit fo);
    lit($sformatf("dut%0d out", u), o, acc[u][KK[u]-1]);
    lit($sformatf("dut%0d out_valid", u), longint'(vo), longint'(ev[u]));
    lit($sformatf("dut%0d sat_flag", u), longint'(fo), longint'(ef[u]));
  endtask

  always @(negedge clk) begin
    if (chk_en && clr_n) begin
      cmp(0, longint'(b0.out), b0.out_valid, b0.sat_flag);
      cmp(1, longint'(b1.out), b1.out_valid, b1.sat_flag);
      cmp(2, longint'(b2.out), b2.out_valid, b2.sat_flag);
      cmp(3, longint'(b3.out), b3.out_valid, b3.sat_flag);
    end
  end

  task automatic step(bit vv, logic signed [15:0] xx, bit dd);
    v = vv; x = xx; d = dd;
    @(posedge clk);
    mdl_step(vv, longint'(xx), dd);
    #1;
  endtask

  // Reset pulse between edges; outputs must fall before any clock edge.
  task automatic areset();
    #1 clr_n = 1'b0;
    #1;
    lit("areset out", longint'(b0.out), 0);
    lit("areset out_valid", longint'(b0.out_valid), 0);
    lit("areset sat_flag u3", longint'(b3.sat_flag), 0);
    mdl_reset();
    #1 clr_n = 1'b1;
  endtask

  task automatic scen1(string tag);
    int e1 [5] = '{0, 0, 1, 4, 10};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'sd1, 1'b0);
      lit({tag, " out"}, longint'(b0.out), e1[i]);
      lit({tag, " model"}, acc[0][2], e1[i]);
      lit({tag, " out_valid"}, longint'(b0.out_valid), 1);
    end
  endtask

  initial begin
    mdl_reset();
    #12;
    lit("reset out", longint'(b0.out), 0);
    lit("reset out_valid", longint'(b0.out_valid), 0);
    lit("reset sat_flag", longint'(b2.sat_flag), 0);
    clr_n = 1'b1;
    chk_en = 1'b1;

    scen1("s1");
    step(1'b0, 16'sd0, 1'b1);
    lit("dump out", longint'(b0.out), 0);

    // Impulse with idle gaps between samples.
    step(1'b1, 16'sd1000, 1'b0); lit("s2 out a", longint'(b0.out), 0);
    step(1'b0, 16'sd0, 1'b0);    lit("s2 gap valid", longint'(b0.out_valid), 0);
    step(1'b1, 16'sd0, 1'b0);    lit("s2 out b", longint'(b0.out), 0);
    step(1'b1, 16'sd0, 1'b0);    lit("s2 out c", longint'(b0.out), 1000);
    step(1'b0, 16'sd0, 1'b0);    lit("s2 gap hold", longint'(b0.out), 1000);
    step(1'b1, 16'sd0, 1'b0);    lit("s2 out d", longint'(b0.out), 3000);
    step(1'b1, 16'sd0, 1'b0);    lit("s2 out e", longint'(b0.out), 6000);
    lit("s2 model", acc[0][2], 6000);

    // Wrap vs saturate at the 16-bit boundary.
    step(1'b0, 16'sd0, 1'b1);
    step(1'b1, 16'sd32767, 1'b0);
    lit("s3 wrap a", longint'(b1.out), 32767);
    lit("s4 sat a", longint'(b2.out), 32767);
    step(1'b1, 16'sd32767, 1'b0);
    lit("s3 wrap b", longint'(b1.out), -2);
    lit("s3 flag", longint'(b1.sat_flag), 0);
    lit("s4 sat b", longint'(b2.out), 32767);
    lit("s4 flag", longint'(b2.sat_flag), 1);
    step(1'b0, 16'sd0, 1'b0);
    lit("s4 flag sticky", longint'(b2.sat_flag), 1);
    step(1'b0, 16'sd0, 1'b1);
    lit("s4 flag dump", longint'(b2.sat_flag), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, -16'sd32768, 1'b0);
      lit("s4 neg clamp", longint'(b2.out), -32768);
    end
    lit("s4 neg flag", longint'(b2.sat_flag), 1);

    // Mid-stream dump carrying a sample.
    for (int i = 0; i < 3; i++) step(1'b1, 16'sd5, 1'b0);
    step(1'b1, 16'sd7, 1'b1);
    lit("s5 out", longint'(b0.out), 0);
    lit("s5 model acc0", acc[0][0], 7);
    step(1'b1, 16'sd0, 1'b0); lit("s5 out a", longint'(b0.out), 0);
    step(1'b1, 16'sd0, 1'b0); lit("s5 out b", longint'(b0.out), 7);
    step(1'b0, 16'sd0, 1'b1);
    lit("s5 dump out", longint'(b0.out), 0);
    lit("s5 dump valid", longint'(b0.out_valid), 0);

    // Async reset mid-stream, then the first sequence must reproduce.
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd300, 1'b0);
    areset();
    scen1("s6");

    for (int i = 0; i < 3000; i++) begin
      int t;
      logic signed [15:0] xr;
      t = $urandom_range(0, 200);
      xr = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(t - 100);
      step($urandom_range(0, 9) < 7, xr, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) areset();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
